probe_row_hasher: RTL and testbench

- Upstream feeder for the probe engine. Pops fact-table rows from a first-word-fall-through (FWFT) input FIFO and computes a multiplicative hash of each key.
- Emits (row value, hash-table bucket address) pairs into the probe engine's row FIFO interface.
- Honours that FIFO's almost-full back-pressure.
- Counts rows against a programmed total and raises done when every row has been emitted.

---
 rtl/probe_row_hasher_if.sv | 29 ++
 rtl/probe_row_hasher.sv | 119 +++++++++++
 tb/tb_probe_row_hasher.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/probe_row_hasher_if.sv
// Row-hasher bus: run control, FWFT fact-FIFO read side and row-FIFO write side.
// The hasher connects through the slave modport; its driver uses master.
interface probe_row_hasher_if;
    logic        start_in;
    logic [47:0] row_count_in;
    logic [47:0] ht_base_in;
    logic        done;
    logic        fact_empty_in;
    logic        fact_read_en_out;
    logic [63:0] fact_data_in;
    logic        row_afull_in;
    logic        row_write_en_out;
    logic [63:0] row_value_out;
    logic [63:0] row_hash_value_out;

    modport master (
        output start_in, row_count_in, ht_base_in,
        output fact_empty_in, fact_data_in, row_afull_in,
        input  done, fact_read_en_out,
        input  row_write_en_out, row_value_out, row_hash_value_out
    );

    modport slave (
        input  start_in, row_count_in, ht_base_in,
        input  fact_empty_in, fact_data_in, row_afull_in,
        output done, fact_read_en_out,
        output row_write_en_out, row_value_out, row_hash_value_out
    );
endinterface

// File: rtl/probe_row_hasher.sv
// Pops fact rows from an FWFT FIFO, hashes each key multiplicatively into a bucket
// byte address and streams (row, address) pairs to the probe engine's row FIFO.
module probe_row_hasher #(
    parameter logic [63:0] HASH_MULT  = 64'h9E3779B97F4A7C15,
    parameter int          TABLE_BITS = 20
) (
    input  logic               clk,
    input  logic               rst,
    probe_row_hasher_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]            state;
    logic [47:0]           count;
    logic [47:0]           base;
    logic [47:0]           issued;
    logic [47:0]           emitted;
    logic [47:0]           emitted_next;
    logic                  pop;
    logic                  emit;

    logic                  vld_p0;
    logic                  vld_p1;
    logic                  vld_p2;
    logic [63:0]           key_p0;
    logic [63:0]           key_p1;
    logic [TABLE_BITS-1:0] index_p1;
    logic [63:0]           key_p2;
    logic [47:0]           addr_p2;

    // Bucket byte address: 8-byte buckets, 48-bit arithmetic that wraps silently.
    function automatic logic [47:0] bucket_addr(input logic [TABLE_BITS-1:0] index,
                                                input logic [47:0]           table_base);
        logic [47:0] offset;
        offset = 48'(index) << 3;
        return table_base + offset;
    endfunction

    assign pop = (state == ST_RUN) && !bus.fact_empty_in && !bus.row_afull_in &&
                 (issued != count);
    assign emit         = vld_p2;
    assign emitted_next = emitted + {47'd0, emit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= 48'd0;
            base    <= 48'd0;
            issued  <= 48'd0;
            emitted <= 48'd0;
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    if (bus.start_in) begin
                        count   <= bus.row_count_in;
                        base    <= bus.ht_base_in;
                        issued  <= 48'd0;
                        emitted <= 48'd0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pop) begin
                        issued <= issued + 48'd1;
                    end
                    emitted <= emitted_next;
                    // Finishing on the post-write count lets done rise right after the last write.
                    if (emitted_next == count) begin
                        state <= ST_FIN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pipeline valids: one row per cycle, never stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= pop;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // Stage p0 captures the key; stage p1 multiplies and keeps only the index bits.
    always_ff @(posedge clk) begin
        if (pop) begin
            key_p0 <= bus.fact_data_in;
        end
        key_p1   <= key_p0;
        index_p1 <= TABLE_BITS'((key_p0 * HASH_MULT) >> (64 - TABLE_BITS));
    end

    // Stage p2 feeds the outputs, so it is cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_p2  <= 64'd0;
            addr_p2 <= 48'd0;
        end else begin
            key_p2  <= key_p1;
            addr_p2 <= bucket_addr(index_p1, base);
        end
    end

    assign bus.fact_read_en_out   = pop;
    assign bus.row_write_en_out   = vld_p2;
    assign bus.row_value_out      = key_p2;
    assign bus.row_hash_value_out = {16'd0, addr_p2};
    assign bus.done               = (state == ST_FIN);

endmodule

// File: tb/tb_probe_row_hasher.sv
// Randomized self-checking bench for probe_row_hasher with an FWFT FIFO model
// and a hash/ordering scoreboard.
module tb_probe_row_hasher;
    localparam logic [63:0] HASH_MULT  = 64'h9E3779B97F4A7C15;
    localparam int          TABLE_BITS = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    probe_row_hasher_if ifc();

    probe_row_hasher #(.HASH_MULT(HASH_MULT), .TABLE_BITS(TABLE_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [63:0] fq[$];
    logic [63:0] exp_val[$];
    logic [63:0] exp_addr[$];
    int          exp_cyc[$];
    logic [63:0] wlog[$];
    logic [63:0] vlog[$];
    int          n_pop, n_wr, first_wr, last_wr, done_cyc, start_cyc;
    logic        prev_done, done_s, gap;
    logic [47:0] m_base;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: top TABLE_BITS of the 64-bit product pick the bucket, 8 bytes each.
    function automatic logic [63:0] ref_addr(input logic [63:0] key, input logic [47:0] b);
        logic [63:0]     prod;
        longint unsigned idx;
        logic [47:0]     a;
        prod = key * HASH_MULT;
        idx  = prod >> (64 - TABLE_BITS);
        a    = b + 48'(idx * 8);
        return {16'h0, a};
    endfunction

    function automatic logic [63:0] wl(input int i);
        return (wlog.size() > i) ? wlog[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic logic [63:0] vl(input int i);
        return (vlog.size() > i) ? vlog[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    task automatic drive_fifo();
        ifc.fact_empty_in = (fq.size() == 0) || gap;
        ifc.fact_data_in  = (fq.size() != 0) ? fq[0] : 64'h0;
    endtask

    // One clock: sample at the falling edge, update the FIFO model after the rising edge.
    task automatic tick();
        logic pop_s, wr_s;
        @(negedge clk);
        cyc++;
        pop_s  = ifc.fact_read_en_out;
        wr_s   = ifc.row_write_en_out;
        done_s = ifc.done;
        if (pop_s) begin
            chk("pop_under_afull", 64'(ifc.row_afull_in), 64'h0);
            chk("pop_when_empty", 64'(ifc.fact_empty_in), 64'h0);
            if (fq.size() != 0) begin
                exp_val.push_back(fq[0]);
                exp_addr.push_back(ref_addr(fq[0], m_base));
                exp_cyc.push_back(cyc);
            end
            n_pop++;
        end
        if (wr_s) begin
            n_wr++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            wlog.push_back(ifc.row_hash_value_out);
            vlog.push_back(ifc.row_value_out);
            if (exp_val.size() == 0) begin
                chk("unexpected_write", 64'(wr_s), 64'h0);
            end else begin
                chk("row_value", ifc.row_value_out, exp_val.pop_front());
                chk("row_hash", ifc.row_hash_value_out, exp_addr.pop_front());
                chk("latency", 64'(cyc - exp_cyc.pop_front()), 64'd3);
            end
        end
        if (done_s && !prev_done) done_cyc = cyc;
        prev_done = done_s;
        @(posedge clk);
        #1;
        if (pop_s && fq.size() != 0) void'(fq.pop_front());
        drive_fifo();
    endtask

    task automatic start_run(input logic [47:0] cnt, input logic [47:0] b);
        ifc.start_in     = 1'b1;
        ifc.row_count_in = cnt;
        ifc.ht_base_in   = b;
        m_base   = b;
        n_pop    = 0;
        n_wr     = 0;
        first_wr = -1;
        last_wr  = -1;
        done_cyc = -1;
        wlog.delete();
        vlog.delete();
        tick();
        start_cyc    = cyc;
        ifc.start_in = 1'b0;
    endtask

    // A start pulse the DUT must ignore; the model keeps its configuration.
    task automatic stray_start(input logic [47:0] cnt);
        ifc.start_in     = 1'b1;
        ifc.row_count_in = cnt;
        ifc.ht_base_in   = 48'h0BAD_0000;
        tick();
        ifc.start_in = 1'b0;
    endtask

    task automatic run_until_done(input int max, input string tag);
        int i;
        i = 0;
        do begin
            tick();
            i++;
        end while (!done_s && i < max);
        chk(tag, 64'(done_s), 64'h1);
    endtask

    function automatic logic [47:0] rand48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    initial begin
        int          i, hold_pop, hold_wr, wr_before, pop_before;
        logic [47:0] b;

        rst = 1'b1;
        ifc.start_in = 1'b0;
        ifc.row_count_in = 48'h0;
        ifc.ht_base_in = 48'h0;
        ifc.row_afull_in = 1'b0;
        gap = 1'b0;
        prev_done = 1'b0;
        done_s = 1'b0;
        m_base = 48'h0;
        n_pop = 0; n_wr = 0; first_wr = -1; last_wr = -1; done_cyc = -1; start_cyc = 0;
        drive_fifo();
        repeat (3) tick();
        chk("reset_done", 64'(ifc.done), 64'h0);
        chk("reset_write_en", 64'(ifc.row_write_en_out), 64'h0);
        chk("reset_read_en", 64'(ifc.fact_read_en_out), 64'h0);
        chk("reset_value", ifc.row_value_out, 64'h0);
        chk("reset_hash", ifc.row_hash_value_out, 64'h0);
        rst = 1'b0;
        tick();

        // Single row, known hash
        fq.push_back(64'h1);
        drive_fifo();
        start_run(48'd1, 48'h0);
        run_until_done(20, "t1_done");
        chk("t1_writes", 64'(n_wr), 64'd1);
        chk("t1_hash", wl(0), 64'h4F1BB8);
        chk("t1_value", vl(0), 64'h1);
        chk("t1_done_after_write", 64'(done_cyc - last_wr), 64'd1);

        // Two rows with nonzero base, back to back
        fq.push_back(64'h0);
        fq.push_back(64'h2);
        drive_fifo();
        start_run(48'd2, 48'h1000);
        run_until_done(20, "t2_done");
        chk("t2_writes", 64'(n_wr), 64'd2);
        chk("t2_addr0", wl(0), 64'h1000);
        chk("t2_addr1", wl(1), 64'h1E4778);
        chk("t2_consecutive", 64'(last_wr - first_wr), 64'd1);

        // 100-row stream with almost-full hold, then random back-pressure and gaps
        for (int k = 0; k < 100; k++) fq.push_back({$urandom, $urandom});
        drive_fifo();
        b = rand48();
        start_run(48'd100, b);
        i = 0;
        while (n_pop == 0 && i < 20) begin
            tick();
            i++;
        end
        chk("t3_first_pop", 64'(n_pop), 64'd1);
        ifc.row_afull_in = 1'b1;
        hold_pop = n_pop;
        hold_wr  = n_wr;
        tick();
        stray_start(48'd5);
        repeat (10) tick();
        chk("t3_hold_no_pops", 64'(n_pop - hold_pop), 64'd0);
        chk("t3_hold_writes_le3", 64'((n_wr - hold_wr) <= 3), 64'd1);
        chk("t3_hold_drained", 64'(n_wr), 64'(n_pop));
        i = 0;
        while (!done_s && i < 3000) begin
            ifc.row_afull_in = ($urandom_range(0, 3) == 0);
            gap = ($urandom_range(0, 4) == 0);
            drive_fifo();
            tick();
            i++;
        end
        ifc.row_afull_in = 1'b0;
        gap = 1'b0;
        drive_fifo();
        chk("t3_done", 64'(done_s), 64'h1);
        chk("t3_pops", 64'(n_pop), 64'd100);
        chk("t3_writes", 64'(n_wr), 64'd100);
        chk("t3_scoreboard_empty", 64'(exp_val.size()), 64'd0);
        chk("t3_fifo_empty", 64'(fq.size()), 64'd0);

        // Zero-row run with a stray start during RUN
        fq.push_back(64'h55);
        fq.push_back(64'h66);
        drive_fifo();
        start_run(48'd0, 48'h0);
        stray_start(48'd7);
        tick();
        chk("t4_done", 64'(done_s), 64'h1);
        chk("t4_done_latency", 64'(done_cyc - start_cyc), 64'd2);
        repeat (4) tick();
        chk("t4_no_pops", 64'(n_pop), 64'd0);
        chk("t4_no_writes", 64'(n_wr), 64'd0);
        chk("t4_done_held", 64'(done_s), 64'h1);
        fq.delete();
        drive_fifo();

        // Count smaller than queued rows
        for (int k = 0; k < 6; k++) fq.push_back({$urandom, $urandom});
        drive_fifo();
        start_run(48'd4, rand48());
        run_until_done(50, "t5_done");
        repeat (3) tick();
        chk("t5_pops", 64'(n_pop), 64'd4);
        chk("t5_writes", 64'(n_wr), 64'd4);
        chk("t5_fifo_not_empty", 64'(ifc.fact_empty_in), 64'h0);
        chk("t5_rows_left", 64'(fq.size()), 64'd2);
        chk("t5_done", 64'(done_s), 64'h1);
        fq.delete();
        drive_fifo();

        // Reset with three rows in flight
        for (int k = 0; k < 3; k++) fq.push_back({$urandom, $urandom});
        drive_fifo();
        start_run(48'd10, rand48());
        i = 0;
        while (n_pop < 3 && i < 20) begin
            tick();
            i++;
        end
        chk("t6_three_popped", 64'(n_pop), 64'd3);
        rst = 1'b1;
        exp_val.delete();
        exp_addr.delete();
        exp_cyc.delete();
        wr_before = n_wr;
        for (int k = 0; k < 3; k++) fq.push_back({$urandom, $urandom});
        drive_fifo();
        repeat (5) tick();
        chk("t6_no_writes", 64'(n_wr), 64'(wr_before));
        chk("t6_done_low", 64'(done_s), 64'h0);
        rst = 1'b0;
        pop_before = n_pop;
        repeat (3) tick();
        chk("t6_idle_no_pops", 64'(n_pop), 64'(pop_before));
        chk("t6_idle_done_low", 64'(done_s), 64'h0);
        fq.delete();
        fq.push_back({$urandom, $urandom});
        drive_fifo();
        start_run(48'd1, rand48());
        run_until_done(20, "t6_restart_done");
        chk("t6_restart_writes", 64'(n_wr), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
